// File: rtl/sum_ctrl.sv
// sum_ctrl: Moore control unit that sequences the Sum datapath
// (Sum = Start_Num + ... + End_Num) with start/busy/done handshake,
// iteration counter and watchdog abort to ERR.
module sum_ctrl #(
  parameter logic [7:0] MAX_ITER = 8'd255
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iStart,
  input  logic       iAbort,
  input  logic       iAlt,
  output logic       oASrcSel,
  output logic       oALoad,
  output logic       oSumSrcSel,
  output logic       oSumLoad,
  output logic       oAddSrcSel,
  output logic       oOufBufSel,
  output logic       oBusy,
  output logic       oDone,
  output logic       oErr,
  output logic [7:0] oIterCnt
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CHECK = 3'd2,
    S_SUM   = 3'd3,
    S_INC   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // Control word decoded from a state; packed in port order.
  typedef struct packed {
    logic a_src_sel;
    logic a_load;
    logic sum_src_sel;
    logic sum_load;
    logic add_src_sel;
    logic out_buf_sel;
    logic busy;
    logic done;
    logic err;
  } ctrl_t;

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl_nxt;
  logic   abort_hit;

  // Moore decode of the control word for a given state.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_INIT: begin
        c.a_load   = 1'b1;
        c.sum_load = 1'b1;
        c.busy     = 1'b1;
      end
      S_CHECK: begin
        c.busy = 1'b1;
      end
      S_SUM: begin
        c.add_src_sel = 1'b1;
        c.sum_src_sel = 1'b1;
        c.sum_load    = 1'b1;
        c.busy        = 1'b1;
      end
      S_INC: begin
        c.a_src_sel = 1'b1;
        c.a_load    = 1'b1;
        c.busy      = 1'b1;
      end
      S_DONE: begin
        c.out_buf_sel = 1'b1;
        c.done        = 1'b1;
      end
      S_ERR: begin
        c.err = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign abort_hit = iAbort && (state != S_IDLE);

  // Next-state logic; abort outranks every other transition outside IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (iStart && !iAbort) state_nxt = S_INIT;
      S_INIT:  state_nxt = S_CHECK;
      S_CHECK: begin
        if (iAlt && (oIterCnt == MAX_ITER)) state_nxt = S_ERR;
        else if (iAlt)                      state_nxt = S_SUM;
        else                                state_nxt = S_DONE;
      end
      S_SUM:   state_nxt = S_INC;
      S_INC:   state_nxt = S_CHECK;
      S_DONE:  if (!iStart) state_nxt = S_IDLE;
      S_ERR:   if (!iStart) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_hit) state_nxt = S_IDLE;
    ctrl_nxt = decode(state_nxt);
  end

  // State, iteration counter and control outputs; outputs are registered
  // from the next-state decode so they always match the current state.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= S_IDLE;
      oIterCnt   <= '0;
      oASrcSel   <= 1'b0;
      oALoad     <= 1'b0;
      oSumSrcSel <= 1'b0;
      oSumLoad   <= 1'b0;
      oAddSrcSel <= 1'b0;
      oOufBufSel <= 1'b0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oErr       <= 1'b0;
    end else begin
      state      <= state_nxt;
      oASrcSel   <= ctrl_nxt.a_src_sel;
      oALoad     <= ctrl_nxt.a_load;
      oSumSrcSel <= ctrl_nxt.sum_src_sel;
      oSumLoad   <= ctrl_nxt.sum_load;
      oAddSrcSel <= ctrl_nxt.add_src_sel;
      oOufBufSel <= ctrl_nxt.out_buf_sel;
      oBusy      <= ctrl_nxt.busy;
      oDone      <= ctrl_nxt.done;
      oErr       <= ctrl_nxt.err;
      if (!abort_hit) begin
        if (state == S_INIT)
          oIterCnt <= '0;
        else if ((state == S_INC) && (oIterCnt != {CNT_W{1'b1}}))
          oIterCnt <= oIterCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sum_ctrl.sv
// tb_sum_ctrl: randomized self-checking bench for sum_ctrl with a
// behavioural datapath and a cycle-schedule reference model.
module tb_sum_ctrl;

  localparam int MAX_ITER = 255;

  logic       iClk = 1'b0;
  logic       iRst_n, iStart, iAbort, iAlt;
  logic       oASrcSel, oALoad, oSumSrcSel, oSumLoad, oAddSrcSel;
  logic       oOufBufSel, oBusy, oDone, oErr;
  logic [7:0] oIterCnt;

  logic [7:0] start_num, end_num, dp_a, dp_sum, dp_add, dp_out;
  logic [8:0] act_ctrl;

  int checks = 0;
  int failures = 0;

  always #5 iClk = ~iClk;

  sum_ctrl #(.MAX_ITER(8'(MAX_ITER))) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iAbort(iAbort), .iAlt(iAlt),
    .oASrcSel(oASrcSel), .oALoad(oALoad), .oSumSrcSel(oSumSrcSel),
    .oSumLoad(oSumLoad), .oAddSrcSel(oAddSrcSel), .oOufBufSel(oOufBufSel),
    .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oIterCnt(oIterCnt)
  );

  // Behavioural Sum datapath driven by the controller.
  assign dp_add = oAddSrcSel ? 8'(dp_sum + dp_a) : 8'(dp_a + 8'd1);
  assign iAlt   = (dp_a <= end_num);
  assign dp_out = oOufBufSel ? dp_sum : 8'd0;
  assign act_ctrl = {oASrcSel, oALoad, oSumSrcSel, oSumLoad, oAddSrcSel,
                     oOufBufSel, oBusy, oDone, oErr};

  always_ff @(posedge iClk) begin
    if (oALoad)   dp_a   <= oASrcSel ? dp_add : start_num;
    if (oSumLoad) dp_sum <= oSumSrcSel ? dp_add : 8'd0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected control word c cycles after the start edge; term is the
  // cycle at which DONE/ERR is entered (3 + 3*iterations).
  function automatic logic [8:0] exp_ctrl(input int c, input int term, input bit is_err);
    if (c == 1)        return 9'b010100100;                 // init: A/Sum load
    if (c < term) begin
      case ((c - 2) % 3)
        0:       return 9'b000000100;                       // check
        1:       return 9'b001110100;                       // sum
        default: return 9'b110000100;                       // inc
      endcase
    end
    return is_err ? 9'b000000001 : 9'b000001010;
  endfunction

  // One request; abort_sum > 0 aborts during that SUM cycle.
  task automatic run(input logic [7:0] s, input logic [7:0] e, input int abort_sum);
    int n, term, exp_sum;
    bit is_err;
    if (s > e) n = 0;
    else if (e == 8'd255) n = MAX_ITER + 1;
    else n = int'(e) - int'(s) + 1;
    is_err = (n > MAX_ITER);
    if (is_err) n = MAX_ITER;
    exp_sum = 0;
    for (int k = 0; k < n; k++) exp_sum = (exp_sum + int'(s) + k) % 256;
    term = 3 + 3 * n;
    @(negedge iClk);
    start_num = s; end_num = e; iStart = 1'b1; iRst_n = 1'b1;
    for (int c = 1; c <= term + 2; c++) begin
      @(negedge iClk);
      check_eq("ctrl", 32'(act_ctrl), 32'(exp_ctrl(c, term, is_err)));
      check_eq("excl", 32'(oALoad && oSumLoad && (c != 1)), 32'd0);
      check_eq("bufbusy", 32'(oOufBufSel && oBusy), 32'd0);
      if (c == term) begin
        check_eq("itercnt", 32'(oIterCnt), 32'(n));
        if (!is_err) check_eq("sum", 32'(dp_out), 32'(exp_sum));
      end
      if (abort_sum > 0 && c == 3 + 3 * (abort_sum - 1)) begin
        iAbort = 1'b1; iStart = 1'b0;
        @(negedge iClk);
        check_eq("abort_ctrl", 32'(act_ctrl), 32'd0);
        check_eq("abort_cnt", 32'(oIterCnt), 32'(abort_sum - 1));
        iAbort = 1'b0;
        return;
      end
    end
    iStart = 1'b0;
    @(negedge iClk);
    check_eq("idle", 32'(act_ctrl), 32'd0);
  endtask

  initial begin
    int s, e, n, ab;
    iRst_n = 1'b0; iStart = 1'b1; iAbort = 1'b0;
    start_num = 8'd0; end_num = 8'd10;
    repeat (3) @(negedge iClk);
    check_eq("rst_ctrl", 32'(act_ctrl), 32'd0);
    check_eq("rst_cnt", 32'(oIterCnt), 32'd0);

    run(8'd0, 8'd10, 0);        // release reset with start held
    run(8'd0, 8'd10, 3);        // abort in 3rd SUM
    run(8'd0, 8'd10, 0);        // full run after abort
    run(8'd20, 8'd10, 0);       // empty range
    run(8'd7, 8'd7, 0);         // single iteration
    run(8'd200, 8'd255, 0);     // watchdog to ERR

    // Asynchronous reset mid-run
    @(negedge iClk);
    start_num = 8'd0; end_num = 8'd10; iStart = 1'b1;
    repeat (7) @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    check_eq("async_rst", 32'(act_ctrl), 32'd0);
    check_eq("async_cnt", 32'(oIterCnt), 32'd0);
    @(negedge iClk);
    iStart = 1'b0; iRst_n = 1'b1;

    // Abort in IDLE masks start
    @(negedge iClk);
    iAbort = 1'b1; iStart = 1'b1;
    @(negedge iClk);
    check_eq("idle_abort", 32'(act_ctrl), 32'd0);
    iAbort = 1'b0; iStart = 1'b0;

    for (int i = 0; i < 14; i++) begin
      s = int'($urandom_range(0, 60));
      e = int'($urandom_range(0, 80));
      n = (s > e) ? 0 : e - s + 1;
      ab = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
      run(8'(s), 8'(e), ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
